// File: rtl/cpu_pkg.sv
// Shared CPU definitions: mult/div op encodings and default unit latencies.
package cpu_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    localparam int unsigned MULT_LAT = 5;
    localparam int unsigned DIV_LAT  = 10;

    typedef enum logic [0:0] {StIdle, StRun} md_state_e;

endpackage

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO. The result is computed at launch into
// shadow registers and committed to HI/LO only when the fixed latency expires.
module md_unit
    import cpu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_LAT,
    parameter int unsigned DIV_CYCLES  = DIV_LAT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        write_hi,
    input  logic        write_lo,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    md_state_e       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     hi_q, hi_d, lo_q, lo_d;
    logic [31:0]     shadow_hi_q, shadow_hi_d, shadow_lo_q, shadow_lo_d;
    logic            shadow_we_q, shadow_we_d;

    logic            accept, complete;
    logic [63:0]     prod_s, prod_u;
    logic [31:0]     divisor;
    logic signed [31:0] quo_s, rem_s;
    logic [31:0]     quo_u, rem_u;
    logic            div_ovf;
    logic [31:0]     res_hi, res_lo;
    logic            res_we;

    assign accept   = (state_q == StIdle) && start;
    assign complete = (state_q == StRun) && (cnt_q == CntW'(1));

    // Arithmetic ---------------------------------------------------------------------------
    assign prod_s = $signed({{32{src_a[31]}}, src_a}) * $signed({{32{src_b[31]}}, src_b});
    assign prod_u = {32'b0, src_a} * {32'b0, src_b};

    // A zero divisor is replaced so the dividers never see it; the result is discarded anyway.
    assign divisor = (src_b == 32'd0) ? 32'd1 : src_b;
    assign div_ovf = (src_a == 32'h8000_0000) && (src_b == 32'hFFFF_FFFF);
    assign quo_s   = $signed(src_a) / $signed(divisor);
    assign rem_s   = $signed(src_a) % $signed(divisor);
    assign quo_u   = src_a / divisor;
    assign rem_u   = src_a % divisor;

    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        res_we = 1'b1;
        unique case (md_op)
            MD_MULT:  {res_hi, res_lo} = prod_s;
            MD_MULTU: {res_hi, res_lo} = prod_u;
            MD_DIV: begin
                res_we = (src_b != 32'd0);
                if (div_ovf) begin
                    res_hi = 32'd0;
                    res_lo = 32'h8000_0000;
                end else begin
                    res_hi = rem_s;
                    res_lo = quo_s;
                end
            end
            MD_DIVU: begin
                res_we = (src_b != 32'd0);
                res_hi = rem_u;
                res_lo = quo_u;
            end
            default: ;
        endcase
    end

    // FSM: state register / next state / outputs ----------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    cnt_d   = md_op[1] ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
                end
            end
            StRun: begin
                cnt_d = cnt_q - CntW'(1);
                if (complete) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy = (state_q == StRun);
    end

    // Datapath registers ------------------------------------------------------------------
    always_comb begin
        shadow_hi_d = shadow_hi_q;
        shadow_lo_d = shadow_lo_q;
        shadow_we_d = shadow_we_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        if (accept) begin
            shadow_hi_d = res_hi;
            shadow_lo_d = res_lo;
            shadow_we_d = res_we;
        end
        if (complete) begin
            if (shadow_we_q) begin
                hi_d = shadow_hi_q;
                lo_d = shadow_lo_q;
            end
        end else if ((state_q == StIdle) && !start) begin
            if (write_hi) hi_d = wdata;
            if (write_lo) lo_d = wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q        <= '0;
            lo_q        <= '0;
            shadow_hi_q <= '0;
            shadow_lo_q <= '0;
            shadow_we_q <= 1'b0;
        end else begin
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            shadow_hi_q <= shadow_hi_d;
            shadow_lo_q <= shadow_lo_d;
            shadow_we_q <= shadow_we_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule
